// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI serial receive path: receiver FSM states,
// default bit rate, oversampling factor, System Real-Time byte range and
// small helper functions (majority vote, tick divider calculation).
// -----------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int unsigned MIDI_BAUD  = 32'd31250;
    localparam int unsigned OVERSAMPLE = 32'd16;

    // System Real-Time messages occupy 8'hF8..8'hFF.
    localparam logic [7:0] RT_MIN = 8'hF8;
    localparam logic [7:0] RT_MAX = 8'hFF;

    // Oversample phases (value of ph after the tick advances it).
    localparam logic [3:0] PH_SAMPLE_A = 4'd7;
    localparam logic [3:0] PH_SAMPLE_B = 4'd8;
    localparam logic [3:0] PH_DECIDE   = 4'd9;

    // Two-out-of-three majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Rounded clock divider giving one tick per oversample period.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return (clk_hz + ((baud * ovs) / 32'd2)) / (baud * ovs);
    endfunction

endpackage

// File: rtl/midi_rx_tick_gen.sv
// -----------------------------------------------------------------------------
// midi_rx_tick_gen
// Free-running divider that emits a one-cycle tick every pDiv clocks. A
// synchronous clear restarts the count so the tick phase can be aligned to an
// external event (the start edge of a frame). Usable by a transmitter as well.
// Ports:
//   iCLK  clock
//   iRST  synchronous active-high reset
//   iClr  synchronous counter clear
//   oTick one-cycle tick, every pDiv cycles after the last clear
// -----------------------------------------------------------------------------
module midi_rx_tick_gen #(
    parameter int unsigned pDiv = 32'd100
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iClr,
    output logic oTick
);

    localparam int unsigned     LP_CW  = (pDiv > 32'd1) ? $clog2(pDiv) : 32'd1;
    localparam logic [LP_CW-1:0] LP_TOP = LP_CW'(pDiv - 32'd1);

    logic [LP_CW-1:0] r_cnt;

    // A clear cycle never produces a tick, so the first tick after a clear
    // is always a full period later.
    assign oTick = (r_cnt == LP_TOP) && !iClr;

    // Divider counter: wraps at pDiv-1, restarts on reset or clear.
    always_ff @(posedge iCLK) begin
        if (iRST || iClr) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_TOP) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + LP_CW'(1);
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
// MIDI IN byte receiver: 16x oversampling, 3-sample majority vote per bit,
// one-cycle byte strobe for the downstream decoder, framing-error pulse.
// Optional build macro: MIDI_RT_FILTER_EN -- when defined, System Real-Time
// bytes (8'hF8..8'hFF) are swallowed (no strobe, oMidiRd not updated).
// Ports:
//   iCLK      system clock
//   iRST      synchronous active-high reset
//   iMidiRx   asynchronous serial input, idle high
//   oMidiRd   last received byte (LSB first on the wire)
//   oMidiRe   one-cycle strobe, oMidiRd valid in that cycle
//   oFrameErr one-cycle pulse on a bad stop bit
//   oRxBusy   high while a frame is in progress
// -----------------------------------------------------------------------------
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned pSysClk     = 32'd50_000_000,
    parameter int unsigned pBaud       = MIDI_BAUD,
    parameter int unsigned pOverSample = OVERSAMPLE
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iMidiRx,
    output logic [7:0] oMidiRd,
    output logic       oMidiRe,
    output logic       oFrameErr,
    output logic       oRxBusy
);

    localparam int unsigned LP_DIV = calc_div(pSysClk, pBaud, pOverSample);

    logic       r_sync1;
    logic       r_sync2;
    rx_state_t  r_state;
    logic [3:0] r_ph;
    logic [2:0] r_bit_idx;
    logic       r_s7;
    logic       r_s8;
    logic [7:0] r_shift;
    logic [3:0] r_idle_cnt;
    logic [7:0] r_rd;
    logic       r_re;
    logic       r_ferr;

    logic       w_rx;
    logic       w_tick;
    logic       w_clr;
    logic [3:0] w_ph_nxt;
    logic       w_decide;
    logic       w_vote;
    logic       w_fwd;

    assign w_rx     = r_sync2;
    // Align the oversample phase to the detected start edge.
    assign w_clr    = (r_state == ST_IDLE) && !w_rx;
    assign w_ph_nxt = r_ph + 4'd1;
    assign w_decide = w_tick && (w_ph_nxt == PH_DECIDE);
    assign w_vote   = maj3(r_s7, r_s8, w_rx);

`ifdef MIDI_RT_FILTER_EN
    assign w_fwd = (r_shift < RT_MIN);
`else
    assign w_fwd = 1'b1;
`endif

    assign oMidiRd   = r_rd;
    assign oMidiRe   = r_re;
    assign oFrameErr = r_ferr;
    assign oRxBusy   = (r_state != ST_IDLE);

    midi_rx_tick_gen #(
        .pDiv (LP_DIV)
    ) u_tick (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iClr  (w_clr),
        .oTick (w_tick)
    );

    // Two-stage synchronizer on the asynchronous line, reset to idle level.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= iMidiRx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM with phase counter, bit sampling and registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_ph       <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_shift    <= 8'h00;
            r_idle_cnt <= 4'd0;
            r_rd       <= 8'h00;
            r_re       <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_re   <= 1'b0;
            r_ferr <= 1'b0;
            if (w_tick && (r_state != ST_IDLE)) begin
                r_ph <= w_ph_nxt;
                if (w_ph_nxt == PH_SAMPLE_A) r_s7 <= w_rx;
                if (w_ph_nxt == PH_SAMPLE_B) r_s8 <= w_rx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state <= ST_START;
                        r_ph    <= 4'd0;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was only a glitch.
                    if (w_decide) begin
                        if (w_vote) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_vote, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave at the stop-bit midpoint so a back-to-back start
                    // edge is caught from IDLE.
                    if (w_decide) begin
                        if (w_vote) begin
                            if (w_fwd) begin
                                r_rd <= r_shift;
                                r_re <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr     <= 1'b1;
                            r_idle_cnt <= 4'd0;
                            r_state    <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // Require one full bit time of idle before re-arming.
                    if (w_tick) begin
                        if (!w_rx) begin
                            r_idle_cnt <= 4'd0;
                        end else if (r_idle_cnt == 4'd15) begin
                            r_idle_cnt <= 4'd0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_uart_rx
// Directed and randomized frames on the serial line; received strobes are
// collected by a monitor and compared with the byte stream the bench sent.
// Clock scaled to 2 MHz so one bit is 64 cycles (tick divider 4).
// -----------------------------------------------------------------------------
module tb_midi_uart_rx;

    localparam int LP_DIV = 4;              // 2e6 / (31250*16)
    localparam int LP_BIT = 16 * LP_DIV;    // cycles per bit
    localparam int LP_LAT = 153 * LP_DIV + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rd;
    logic       re;
    logic       fe;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_fall = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_cnt = 0;
    int         excl_viol = 0;

    midi_uart_rx #(
        .pSysClk     (2_000_000),
        .pBaud       (31250),
        .pOverSample (16)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iMidiRx   (rx),
        .oMidiRd   (rd),
        .oMidiRe   (re),
        .oFrameErr (fe),
        .oRxBusy   (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every strobe and error pulse away from the active edge.
    always @(negedge clk) begin
        if (re) begin
            got_q.push_back(rd);
            got_cyc.push_back(cyc);
        end
        if (fe) ferr_cnt++;
        if (re && fe) excl_viol++;
    end

    function automatic int got_at(input int i);
        if (i < got_q.size()) return int'(got_q[i]);
        return -1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < got_cyc.size()) return got_cyc[i];
        return -100000;
    endfunction

    // Reference rule: which received bytes reach the decoder.
    function automatic bit forwarded(input logic [7:0] b);
`ifdef MIDI_RT_FILTER_EN
        return (b < 8'hF8);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame: start, 8 data LSB first, stop. Optional single-sample
    // glitch in frame bit glitch_bit, optional reset assertion at the middle
    // of frame bit rst_bit (left asserted for the caller to release).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen,
                              input int glitch_bit, input int rst_bit);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            if (i == glitch_bit) begin
                repeat (30) @(negedge clk);
                rx = ~fr[i];
                repeat (4) @(negedge clk);
                rx = fr[i];
                repeat (bitlen - 34) @(negedge clk);
            end else if (i == rst_bit) begin
                repeat (bitlen / 2) @(negedge clk);
                rst = 1'b1;
                repeat (bitlen - bitlen / 2) @(negedge clk);
            end else begin
                repeat (bitlen) @(negedge clk);
            end
        end
    endtask

    initial begin
        int base;
        int fbase;
        int lat;
        logic [7:0] b;
        logic [7:0] last_fwd;
        logic [7:0] exp_q[$];
        int bl;
        int gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_rd", rd, 8'h00);
        chk("rst_re", re, 1'b0);
        chk("rst_fe", fe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(2 * LP_BIT);

        // Single byte with latency
        base = got_q.size(); fbase = ferr_cnt;
        send_frame(8'h90, 1'b1, LP_BIT, -1, -1);
        idle(2 * LP_BIT);
        chk("single_cnt", got_q.size() - base, 1);
        chk("single_val", got_at(base), 8'h90);
        chk("single_ferr", ferr_cnt - fbase, 0);
        chk("single_busy", busy, 1'b0);
        lat = cyc_at(base) - t_fall;
        chk("single_latency", (lat >= LP_LAT - 2 && lat <= LP_LAT + 2) ? 1 : 0, 1);

        // Back-to-back stream
        base = got_q.size();
        send_frame(8'h90, 1'b1, LP_BIT, -1, -1);
        send_frame(8'h3C, 1'b1, LP_BIT, -1, -1);
        send_frame(8'h7F, 1'b1, LP_BIT, -1, -1);
        idle(2 * LP_BIT);
        chk("b2b_cnt", got_q.size() - base, 3);
        chk("b2b_v0", got_at(base), 8'h90);
        chk("b2b_v1", got_at(base + 1), 8'h3C);
        chk("b2b_v2", got_at(base + 2), 8'h7F);
        lat = cyc_at(base + 1) - cyc_at(base);
        chk("b2b_gap01", (lat >= 10 * LP_BIT - 4 && lat <= 10 * LP_BIT + 4) ? 1 : 0, 1);
        lat = cyc_at(base + 2) - cyc_at(base + 1);
        chk("b2b_gap12", (lat >= 10 * LP_BIT - 4 && lat <= 10 * LP_BIT + 4) ? 1 : 0, 1);

        // Start glitch of a quarter bit
        base = got_q.size(); fbase = ferr_cnt;
        rx = 1'b0;
        repeat (LP_BIT / 4) @(negedge clk);
        idle(2 * LP_BIT);
        chk("glitch_cnt", got_q.size() - base, 0);
        chk("glitch_ferr", ferr_cnt - fbase, 0);
        chk("glitch_busy", busy, 1'b0);

        // Mid-bit glitch in data bit 3 (frame bit 4) is voted out
        base = got_q.size();
        send_frame(8'h55, 1'b1, LP_BIT, 4, -1);
        idle(2 * LP_BIT);
        chk("vote_cnt", got_q.size() - base, 1);
        chk("vote_val", got_at(base), 8'h55);

        // Bad stop bit, line held low, then recovery
        base = got_q.size(); fbase = ferr_cnt;
        b = 8'($urandom);
        send_frame(b, 1'b0, LP_BIT, -1, -1);
        repeat (3 * LP_BIT) @(negedge clk);
        idle(2 * LP_BIT);
        chk("badstop_ferr", ferr_cnt - fbase, 1);
        chk("badstop_cnt", got_q.size() - base, 0);
        chk("badstop_rd_hold", rd, 8'h55);
        send_frame(8'h80, 1'b1, LP_BIT, -1, -1);
        idle(2 * LP_BIT);
        chk("recover_cnt", got_q.size() - base, 1);
        chk("recover_val", got_at(base), 8'h80);
        chk("recover_ferr", ferr_cnt - fbase, 1);

        // Real-Time byte
        base = got_q.size();
        b = 8'hF8 + 8'($urandom_range(0, 7));
        send_frame(b, 1'b1, LP_BIT, -1, -1);
        idle(2 * LP_BIT);
        chk("rt_cnt", got_q.size() - base, forwarded(b) ? 1 : 0);
        chk("rt_rd", rd, forwarded(b) ? b : 8'h80);

        // Reset during data bit 4 (frame bit 5)
        base = got_q.size(); fbase = ferr_cnt;
        send_frame(8'hA5, 1'b1, LP_BIT, -1, 5);
        idle(4);
        chk("midrst_rd", rd, 8'h00);
        chk("midrst_re", re, 1'b0);
        chk("midrst_fe", fe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(2 * LP_BIT);
        chk("midrst_cnt", got_q.size() - base, 0);
        chk("midrst_ferr", ferr_cnt - fbase, 0);
        send_frame(8'h42, 1'b1, LP_BIT, -1, -1);
        idle(2 * LP_BIT);
        chk("after_rst_cnt", got_q.size() - base, 1);
        chk("after_rst_val", got_at(base), 8'h42);
        last_fwd = 8'h42;

        // Randomized stream with small baud error and random gaps
        base = got_q.size(); fbase = ferr_cnt;
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom);
            bl  = LP_BIT - 1 + int'($urandom_range(0, 2));
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 200));
            send_frame(b, 1'b1, bl, -1, -1);
            if (forwarded(b)) begin
                exp_q.push_back(b);
                last_fwd = b;
            end
            idle(gap);
        end
        idle(3 * LP_BIT);
        chk("rand_cnt", got_q.size() - base, exp_q.size());
        chk("rand_ferr", ferr_cnt - fbase, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("rand_val%0d", k), got_at(base + k), exp_q[k]);
        end
        chk("rand_last_rd", rd, last_fwd);

        chk("pulse_exclusive", excl_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial MIDI byte receiver that sits directly upstream of the MIDI decode unit. It recovers 8-bit bytes from the 31.25 kbaud opto-isolated MIDI IN line using 16x oversampling with majority voting. Each valid byte is presented as the one-cycle byte strobe (`oMidiRd` / `oMidiRe`) that the decode unit consumes. Framing faults are flagged and never forwarded.

## Interface
Parameters:
- `pSysClk`, default 50_000_000: iCLK frequency in Hz.
- `pBaud`, default 31250: MIDI bit rate.
- `pOverSample`, default 16: samples per bit. Fixed at 16; other values are unsupported.

Ports:
- `iCLK`  in  1  system clock; the block has exactly one clock.
- `iRST`  in  1  reset; synchronous, active-high.
- `iMidiRx`  in  1  asynchronous serial MIDI IN. Idle level is high.
- `oMidiRd`  out  8  last received byte. LSB is the first data bit on the wire.
- `oMidiRe`  out  1  one-cycle strobe; `oMidiRd` is valid in that cycle.
- `oFrameErr`  out  1  one-cycle pulse when a frame has a bad stop bit.
- `oRxBusy`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- **Input synchronizer:** two flip-flops on `iMidiRx`, both reset to 1. All logic below uses the synchronized signal `rx_s`.
- **Tick generator:** one-cycle `tick` every DIV = round(pSysClk / (pBaud*16)) cycles. At defaults DIV = 100.
  - The divider counter is cleared on the IDLE→START transition, so sample phase aligns to the start edge.
- **Sample counter:** `ph` (0..15) advances on each tick.
- **Bit sampling:** each bit value is the majority of `rx_s` at ph = 7, 8 and 9. The bit decision is taken at ph = 9.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** when `rx_s` = 0, go to START with ph = 0.
  - **START:** at the bit decision, a majority of 1 is treated as a glitch and the FSM returns to IDLE with no output. A majority of 0 goes to DATA with bit index 0.
  - **DATA:** at each bit decision, shift the bit into shift register bit 7 (shift right). After index 7, go to STOP.
  - **STOP:** at the bit decision:
    - Majority 1: load `oMidiRd` from the shift register, pulse `oMidiRe`, go to IDLE.
    - Majority 0: pulse `oFrameErr`, leave `oMidiRd` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s` = 1 for 16 consecutive ticks (break / stuck-low protection), then go to IDLE.
- **Return to IDLE after STOP:** happens at the stop-bit mid-point. This allows back-to-back frames whose next start bit follows immediately.
- **Reset values:** `oMidiRd` = 8'h00, `oMidiRe` = 0, `oFrameErr` = 0, `oRxBusy` = 0. FSM = IDLE, counters = 0.
- **Reset mid-frame:** the partial byte is discarded and no strobe or error is emitted. Reception restarts on the next falling edge after `iRST` deasserts.
- **Pulse exclusivity:** `oMidiRe` and `oFrameErr` are never high in the same cycle.

## Timing
- **Synchronizer latency:** 2 cycles from `iMidiRx` to `rx_s`.
- **Strobe latency:** `oMidiRe` is registered and rises 1 cycle after the tick of the stop-bit decision. That is about 9.56 bit times after the start edge.
  - At defaults: (9*16 + 9)*100 + 3 ≈ 15303 cycles after the line falls.
- **Strobe width:** `oMidiRe` is exactly 1 cycle. `oMidiRd` holds until the next valid byte.
- **Tolerance:** baud error up to ±3% is tolerated.

## Configuration
- **Macro:** `MIDI_RT_FILTER_EN`.
- **Defined:** received System Real-Time bytes (8'hF8–8'hFF) are dropped.
  - No `oMidiRe` pulse and no update of `oMidiRd`.
  - The byte does not disturb the decoder's running status.
- **Undefined:** every valid byte is forwarded unchanged.

## Structure
- **Shared package `midi_pkg`:**
  - FSM state enum.
  - Default baud constant 31250.
  - Oversample factor 16.
  - Real-Time range constants (RT_MIN = 8'hF8).
- **Sub-module `midi_rx_tick_gen`:**
  - Parameterized divider.
  - Synchronous clear input and one-cycle `tick` output.
  - Reusable for a future MIDI transmitter.

## Test plan
All scenarios use defaults: 50 MHz, 1 bit = 1600 cycles.
- **Single byte:** frame 8'h90 → exactly one `oMidiRe` with `oMidiRd` = 8'h90, no `oFrameErr`, `oRxBusy` low afterwards.
- **Back-to-back stream:** 8'h90, 8'h3C, 8'h7F with zero idle gap → three strobes in order with those values, spaced 16000 ± 100 cycles.
- **Start glitch:** 400-cycle low pulse on an idle line → no `oMidiRe`, no `oFrameErr`, FSM back in IDLE.
  - Separately, a 150-cycle glitch in mid-data bit 3 of 8'h55 → 8'h55 is still received (majority vote).
- **Bad stop bit:** frame with stop = 0, then line low for 3 bit times, then frame 8'h80 → one `oFrameErr` pulse, `oMidiRd` stays at its prior value, then 8'h80 is received.
- **Real-Time byte:** 8'hF8 → strobe with 8'hF8 when the macro is undefined; no strobe and `oMidiRd` unchanged when `MIDI_RT_FILTER_EN` is defined.
- **Reset mid-frame:** `iRST` asserted during data bit 4 of 8'hA5 → no strobe, outputs at reset values. The following 8'h42 is received correctly.
